// File: rtl/action_pkg.sv
// Shared action-stage definitions: action word layout, datapath widths and
// the fixed latency of the alu_1 instance.
package action_pkg;

   localparam int unsigned ACTION_LEN = 25;
   localparam int unsigned DATA_WIDTH = 48;
   localparam int unsigned OPCODE_HI  = 24;
   localparam int unsigned OPCODE_LO  = 21;
   localparam int unsigned ALU_LAT    = 2;

   function automatic logic [OPCODE_HI-OPCODE_LO:0] opcode_of(
      input logic [ACTION_LEN-1:0] action
   );
      return action[OPCODE_HI:OPCODE_LO];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr,
// wrapping at NUM_REQ-1 (NUM_REQ need not be a power of two).
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [TAG_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [TAG_W-1:0]   idx,
   output logic               any
);

   localparam int N = int'(NUM_REQ);

   // Scan NUM_REQ positions starting at ptr; the first eligible lane wins.
   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && elig[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = TAG_W'(j);
         end
      end
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between NUM_REQ lanes: round-robin issue, a tag pipe matched
// to the ALU latency, and one-hot steering of results back to the issuing lane.
// Optional build macro ALU_ARB_STATS_EN adds per-lane grant and idle counters.
module alu_issue_arbiter
   import action_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ACTION_LEN = action_pkg::ACTION_LEN,
   parameter int unsigned DATA_WIDTH = action_pkg::DATA_WIDTH,
   parameter int unsigned ALU_LAT    = action_pkg::ALU_LAT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             arb_en,
   input  logic [NUM_REQ-1:0]               lane_mask,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ACTION_LEN-1:0]    req_action,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op1,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op2,
   output logic [ACTION_LEN-1:0]            alu_action,
   output logic                             alu_action_valid,
   output logic [DATA_WIDTH-1:0]            alu_op1,
   output logic [DATA_WIDTH-1:0]            alu_op2,
   input  logic [DATA_WIDTH-1:0]            alu_result,
   input  logic                             alu_result_valid,
   output logic [NUM_REQ-1:0]               resp_valid,
   output logic [DATA_WIDTH-1:0]            resp_data,
   output logic                             err_sticky
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]            grant_cnt,
   output logic [31:0]                      idle_cnt
`endif
);

   localparam int unsigned TAG_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    elig, gnt;
   logic [TAG_W-1:0]      win_idx, rr_ptr_q;
   logic                  win_any;
   logic [ACTION_LEN-1:0] win_action;
   logic [DATA_WIDTH-1:0] win_op1, win_op2;

   logic [ALU_LAT:0]      pipe_v_q;
   logic [TAG_W-1:0]      pipe_tag_q [ALU_LAT+1];
   logic                  head_v;
   logic [NUM_REQ-1:0]    head_onehot;

   assign elig      = req_valid & lane_mask & {NUM_REQ{arb_en}};
   assign req_ready = gnt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .TAG_W   (TAG_W)
   ) u_rr_pick (
      .elig (elig),
      .ptr  (rr_ptr_q),
      .gnt  (gnt),
      .idx  (win_idx),
      .any  (win_any)
   );

   // One-hot mux of the winning lane's action and operands.
   always_comb begin
      win_action = '0;
      win_op1    = '0;
      win_op2    = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt[i]) begin
            win_action = req_action[i*ACTION_LEN +: ACTION_LEN];
            win_op1    = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
            win_op2    = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Issue registers and round-robin pointer; data holds when nothing issues.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_action_valid <= 1'b0;
         alu_action       <= '0;
         alu_op1          <= '0;
         alu_op2          <= '0;
         rr_ptr_q         <= '0;
      end else begin
         alu_action_valid <= win_any;
         if (win_any) begin
            alu_action <= win_action;
            alu_op1    <= win_op1;
            alu_op2    <= win_op2;
            rr_ptr_q   <= (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

   // Tag pipe: stage ALU_LAT lines up with the ALU result of the same op.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v_q <= '0;
         for (int s = 0; s <= int'(ALU_LAT); s++) pipe_tag_q[s] <= '0;
      end else begin
         pipe_v_q      <= {pipe_v_q[ALU_LAT-1:0], win_any};
         pipe_tag_q[0] <= win_idx;
         for (int s = 1; s <= int'(ALU_LAT); s++) pipe_tag_q[s] <= pipe_tag_q[s-1];
      end
   end

   assign head_v      = pipe_v_q[ALU_LAT];
   assign head_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pipe_tag_q[ALU_LAT];

   // Result steering; a valid mismatch latches the error and drops the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= '0;
         resp_data  <= '0;
         err_sticky <= 1'b0;
      end else begin
         resp_valid <= (alu_result_valid && head_v) ? head_onehot : '0;
         if (alu_result_valid && head_v) resp_data <= alu_result;
         if (alu_result_valid != head_v) err_sticky <= 1'b1;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [31:0] grant_cnt_q [NUM_REQ];
   logic [31:0] idle_cnt_q;

   // Saturating per-lane handshake counters and starvation-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REQ); i++) grant_cnt_q[i] <= '0;
         idle_cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
         end
         if (elig == '0 && req_valid != '0 && idle_cnt_q != '1) idle_cnt_q <= idle_cnt_q + 32'd1;
      end
   end

   // Flatten the counter array onto the output bus.
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) grant_cnt[i*32 +: 32] = grant_cnt_q[i];
   end

   assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: ALU stub with fixed latency, a cycle-level
// behavioural model, directed scenarios and randomized traffic.
module tb_alu_issue_arbiter;
   import action_pkg::*;

   localparam int NR  = 4;
   localparam int AL  = 25;
   localparam int DW  = 48;
   localparam int LAT = 2;
   localparam int RING = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arb_en = 1'b0;
   logic [NR-1:0] lane_mask = '0;
   logic [NR-1:0] req_valid = '0;
   logic [NR-1:0] req_ready;
   logic [NR*AL-1:0] req_action;
   logic [NR*DW-1:0] req_op1, req_op2;
   logic [AL-1:0] alu_action;
   logic alu_action_valid;
   logic [DW-1:0] alu_op1, alu_op2;
   logic [DW-1:0] alu_result;
   logic alu_result_valid;
   logic [NR-1:0] resp_valid;
   logic [DW-1:0] resp_data;
   logic err_sticky;
`ifdef ALU_ARB_STATS_EN
   logic [NR*32-1:0] grant_cnt;
   logic [31:0] idle_cnt;
`endif

   logic [AL-1:0] lane_act [NR];
   logic [DW-1:0] lane_op1 [NR];
   logic [DW-1:0] lane_op2 [NR];
   logic inj = 1'b0;

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign req_action[g*AL +: AL] = lane_act[g];
      assign req_op1[g*DW +: DW]    = lane_op1[g];
      assign req_op2[g*DW +: DW]    = lane_op2[g];
   end

   always #5 clk = ~clk;

   alu_issue_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .arb_en           (arb_en),
      .lane_mask        (lane_mask),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_action       (req_action),
      .req_op1          (req_op1),
      .req_op2          (req_op2),
      .alu_action       (alu_action),
      .alu_action_valid (alu_action_valid),
      .alu_op1          (alu_op1),
      .alu_op2          (alu_op2),
      .alu_result       (alu_result),
      .alu_result_valid (alu_result_valid),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .err_sticky       (err_sticky)
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_cnt        (grant_cnt),
      .idle_cnt         (idle_cnt)
`endif
   );

   function automatic logic [DW-1:0] alu_fn(input logic [AL-1:0] a,
                                            input logic [DW-1:0] x, input logic [DW-1:0] y);
      case (opcode_of(a))
         4'd1:    return x + y;
         4'd2:    return x - y;
         4'd3:    return x & y;
         default: return x ^ y;
      endcase
   endfunction

   // ALU stub: fixed latency, never reset, so ops in flight at reset still return.
   logic          stub_v [LAT];
   logic [DW-1:0] stub_d [LAT];
   initial for (int s = 0; s < LAT; s++) begin stub_v[s] = 1'b0; stub_d[s] = '0; end
   always @(posedge clk) begin
      stub_v[0] <= alu_action_valid;
      stub_d[0] <= alu_fn(alu_action, alu_op1, alu_op2);
      for (int s = 1; s < LAT; s++) begin
         stub_v[s] <= stub_v[s-1];
         stub_d[s] <= stub_d[s-1];
      end
   end
   assign alu_result_valid = stub_v[LAT-1] | inj;
   assign alu_result       = stub_d[LAT-1];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: expected registered outputs for the next cycle,
   // plus a ring of issued ops indexed by issue cycle.
   bit            m_on = 0;
   int            m_ptr, cyc = 0;
   bit            m_av, m_err;
   logic [AL-1:0] m_act;
   logic [DW-1:0] m_op1, m_op2, m_rd;
   logic [NR-1:0] m_rv;
   bit            r_v [RING];
   int            r_lane [RING];
   logic [DW-1:0] r_res [RING];

   always @(negedge clk) begin
      int w, head, slot;
      logic [NR-1:0] exp_ready;
      if (m_on) begin
         check("alu_action_valid", alu_action_valid, m_av);
         check("alu_action", alu_action, m_act);
         check("alu_op1", alu_op1, m_op1);
         check("alu_op2", alu_op2, m_op2);
         check("resp_valid", resp_valid, m_rv);
         if (m_rv != 0) check("resp_data", resp_data, m_rd);
         check("err_sticky", err_sticky, m_err);
      end
      if (rst) begin
         m_on = 1; m_ptr = 0; m_av = 0; m_err = 0; m_rv = '0;
         m_act = '0; m_op1 = '0; m_op2 = '0; m_rd = '0;
         for (int s = 0; s < RING; s++) r_v[s] = 0;
      end else if (m_on) begin
         w = -1;
         for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (w < 0 && req_valid[j] && lane_mask[j] && arb_en) w = j;
         end
         exp_ready = '0;
         if (w >= 0) exp_ready[w] = 1'b1;
         check("req_ready", req_ready, exp_ready);
         slot = cyc % RING;
         head = (cyc + RING - (LAT + 1)) % RING;
         m_rv = '0;
         if (alu_result_valid && r_v[head]) begin
            m_rv[r_lane[head]] = 1'b1;
            m_rd = r_res[head];
         end
         if (alu_result_valid != r_v[head]) m_err = 1;
         if (w >= 0) begin
            m_av = 1; m_act = lane_act[w]; m_op1 = lane_op1[w]; m_op2 = lane_op2[w];
            m_ptr = (w + 1) % NR;
            r_v[slot] = 1; r_lane[slot] = w; r_res[slot] = alu_fn(m_act, m_op1, m_op2);
         end else begin
            m_av = 0; r_v[slot] = 0;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; inj = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic capture_grants(input string name, input logic [NR-1:0] exp [], input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check(name, req_ready, exp[i]);
         step();
      end
   endtask

   initial begin
      logic [NR-1:0] seq_all [] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [NR-1:0] seq_msk [] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      int cnt;
      for (int i = 0; i < NR; i++) begin
         lane_act[i] = 25'(i + 1) << 21;
         lane_op1[i] = 48'(100 * (i + 1));
         lane_op2[i] = 48'(7 + i);
      end
      step(); step();
      rst = 1'b0;
      arb_en = 1'b1; lane_mask = '1;

      // Single request on lane 2: add 10 + 3.
      lane_act[2] = 25'b0001 << 21; lane_op1[2] = 48'd10; lane_op2[2] = 48'd3;
      req_valid = 4'b0100;
      @(negedge clk);
      check("t1_ready", req_ready, 4'b0100);
      step();
      req_valid = '0;
      @(negedge clk);
      check("t1_issue_valid", alu_action_valid, 1'b1);
      check("t1_issue_op1", alu_op1, 48'd10);
      step(); step(); step();
      @(negedge clk);
      check("t1_resp_valid", resp_valid, 4'b0100);
      check("t1_resp_data", resp_data, 48'd13);
      repeat (3) step();

      // All lanes valid from rr_ptr = 0.
      do_reset();
      req_valid = 4'b1111;
      capture_grants("t2_rr_order", seq_all, 5);
      req_valid = '0;
      repeat (6) step();

      // Lane 2 masked, then arbitration disabled mid-burst.
      do_reset();
      lane_mask = 4'b1011; req_valid = 4'b1111;
      capture_grants("t3_masked_order", seq_msk, 4);
      arb_en = 1'b0;
      @(negedge clk);
      check("t3_no_grant", req_ready, 4'b0000);
      cnt = 0;
      repeat (7) begin
         step();
         @(negedge clk);
         if (resp_valid != 0) cnt++;
      end
      check("t3_drained_resps", 64'(cnt), 64'd3);
      arb_en = 1'b1; lane_mask = '1; req_valid = '0;
      step();

      // Spurious ALU result with empty pipe.
      inj = 1'b1;
      step();
      inj = 1'b0;
      @(negedge clk);
      check("t4_err_set", err_sticky, 1'b1);
      check("t4_no_resp", resp_valid, 4'b0000);
      repeat (3) step();
      @(negedge clk);
      check("t4_err_holds", err_sticky, 1'b1);

      // Reset with two ops in flight.
      do_reset();
      req_valid = 4'b1111;
      step(); step();
      req_valid = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("t5_valid_cleared", alu_action_valid, 1'b0);
      check("t5_resp_cleared", resp_valid, 4'b0000);
      check("t5_err_cleared", err_sticky, 1'b0);
      req_valid = 4'b1111;
      #1;
      check("t5_lane0_first", req_ready, 4'b0001);
      step();
      req_valid = '0;
      @(negedge clk);
      check("t5_stale_err", err_sticky, 1'b1);
      check("t5_stale_no_resp", resp_valid, 4'b0000);
      repeat (6) step();

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         req_valid = 4'($urandom);
         lane_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
         arb_en    = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               lane_act[i] = 25'($urandom);
               lane_op1[i] = {16'($urandom), 32'($urandom)};
               lane_op2[i] = {16'($urandom), 32'($urandom)};
            end
         end
         step();
      end
      req_valid = '0; arb_en = 1'b1; lane_mask = '1;
      repeat (8) step();

`ifdef ALU_ARB_STATS_EN
      do_reset();
      req_valid = 4'b1111;
      repeat (100) step();
      req_valid = '0;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         cnt = int'(grant_cnt[i*32 +: 32]);
         check("stats_grant_cnt_in_24_26", 64'(cnt >= 24 && cnt <= 26), 64'd1);
      end
      check("stats_idle_cnt", idle_cnt, 32'd0);
      repeat (6) step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one alu_1 instance between NUM_REQ sub_action lanes inside an action stage.
- Each cycle it round-robin arbitrates the valid lanes and registers the winner's action and operands onto the ALU input.
- It tracks the winner's lane index through a tag pipeline matched to the ALU latency, then steers the ALU result back to that lane as a one-hot response.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..16).
- ACTION_LEN, 25, action word width; opcode in [24:21].
- DATA_WIDTH, 48, operand/result width.
- ALU_LAT, 2, cycles from ALU action_valid sampled to container_out_valid.
- TAG_W, $clog2(NUM_REQ), lane tag width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- arb_en  in  1  1 = arbitration enabled; 0 = no new grants, in-flight ops complete.
- lane_mask  in  NUM_REQ  1 = lane eligible (configuration).
- req_valid  in  NUM_REQ  per-lane request.
- req_ready  out  NUM_REQ  per-lane grant (one-hot or zero).
- req_action  in  NUM_REQ*ACTION_LEN  lane i at [i*ACTION_LEN +: ACTION_LEN].
- req_op1  in  NUM_REQ*DATA_WIDTH  operand 1 per lane.
- req_op2  in  NUM_REQ*DATA_WIDTH  operand 2 per lane.
- alu_action  out  ACTION_LEN  to ALU action_in.
- alu_action_valid  out  1  to ALU action_valid.
- alu_op1  out  DATA_WIDTH  to ALU operand_1_in.
- alu_op2  out  DATA_WIDTH  to ALU operand_2_in.
- alu_result  in  DATA_WIDTH  from ALU container_out.
- alu_result_valid  in  1  from ALU container_out_valid.
- resp_valid  out  NUM_REQ  one-hot result strobe to the owning lane.
- resp_data  out  DATA_WIDTH  result, broadcast to all lanes.
- err_sticky  out  1  tag/result mismatch seen; cleared only by rst.

Behaviour:
- Reset (rst high at a clk edge) sets all registered outputs to 0, rr_ptr to 0 and the tag pipeline to empty; in-flight ops are dropped.
- After reset, results from the ALU for ops issued before reset are ignored: the tag pipe is empty, so a valid result then sets err_sticky only if it arrives after rst deasserts.
- Eligible lanes: elig = req_valid & lane_mask & {NUM_REQ{arb_en}}.
- Arbitration is combinational. The winner is the first set bit of elig scanning from rr_ptr upward, with wrap.
- req_ready = one-hot(winner), or 0 when elig is 0. Handshake happens in the cycle where req_valid[i] and req_ready[i] are both high.
- On handshake at cycle T:
  - alu_action, alu_op1 and alu_op2 are registered from the winning lane; alu_action_valid = 1 at T+1.
  - rr_ptr becomes (winner+1) mod NUM_REQ.
- With no handshake: alu_action_valid = 0, the data regs hold their values, and rr_ptr is unchanged.
- Throughput is one issue per cycle. Fairness: a continuously valid, unmasked lane is granted within NUM_REQ cycles.
- Tag pipe: ALU_LAT+1 stages of {valid, tag}, loaded with the winner at T and shifted every cycle.
- Result: when alu_result_valid = 1 and pipe head valid = 1, then on the next cycle resp_valid = one-hot(head tag) and resp_data = alu_result. Total latency from handshake to resp_valid is ALU_LAT+2 cycles (T+4 at default).
- Mismatch: if alu_result_valid != head valid, set err_sticky, drive no resp_valid for that slot, and keep running.
- Responses have no backpressure; a lane must accept resp_valid whenever it is asserted.
- arb_en falling: an in-progress grant is not withdrawn retroactively (ready is combinational). The pipe drains normally.
- lane_mask change takes effect in the same cycle.
- rr_ptr pointing at a masked lane: the scan skips it; no special case.
- NUM_REQ not a power of 2: rr_ptr wraps at NUM_REQ-1 to 0; tags >= NUM_REQ never occur.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds output grant_cnt (NUM_REQ*32). Each counter counts handshakes for its lane, saturates at 2^32-1, and resets to 0 on rst.
- Also adds output idle_cnt (32), which counts cycles with elig = 0 and req_valid != 0, i.e. starvation by mask or arb_en. Same saturation and reset rules.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package, action_pkg: opcode field position (24:21), ACTION_LEN and DATA_WIDTH defaults, ALU_LAT constant for alu_1 (2).
- One natural sub-module: rr_pick, a combinational round-robin priority picker (elig, ptr -> one-hot, index, any).
- The tag pipe and issue registers stay in the top level.

Test Plan:
- Single lane 2 valid, op1=10, op2=3, action[24:21]=0001, after reset -> req_ready=0100; alu_action_valid at T+1; resp_valid=0100, resp_data=13 at T+4.
- All 4 lanes continuously valid, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; responses are in the same order, one per cycle, with correct tags.
- lane_mask=1011 with all valid -> lane 2 never granted; pattern 0,1,3,0. Clearing arb_en mid-burst -> no new grants; 3 pending responses still delivered.
- Inject alu_result_valid=1 with the pipe empty -> err_sticky=1, resp_valid stays 0; err_sticky holds until rst.
- Assert rst for 1 cycle with 2 ops in flight -> all outputs 0 next cycle; the stale ALU result arriving after rst deasserts sets err_sticky and produces no resp_valid. A new request after reset is granted to lane 0 first.
- With ALU_ARB_STATS_EN: 100 cycles of all lanes valid -> each grant_cnt = 25 (±1 by phase), idle_cnt = 0.
